// File: rtl/perf_counter_bank.sv
// Instruction-statistics counter bank for the MIPS cores: eight decoded event
// classes plus a cycle counter, with wrap/saturate, halt freeze, snapshot and read port.
module perf_counter_bank #(
  parameter int CNT_W    = 11,
  parameter int SATURATE = 0,
  parameter int SNAP_EN  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             branch_taken,
  input  logic             halt,
  input  logic             clear,
  input  logic             snap,
  input  logic [3:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [8:0]       overflow,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] cnt_j,
  output logic [CNT_W-1:0] cnt_clk
);

  localparam int NCH = 9;

  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] snap_q [NCH];
  logic [NCH-1:0]   ev;
  logic [NCH-1:0]   inc;
  logic [CNT_W-1:0] rd_next;

  always_comb begin
    ev    = '0;
    ev[0] = valid && (op == 6'h00);
    ev[1] = valid && (op != 6'h00) && (op != 6'h02) && (op != 6'h03);
    ev[2] = valid && ((op == 6'h02) || (op == 6'h03));
    ev[3] = valid && (op == 6'h23);
    ev[4] = valid && (op == 6'h2B);
    ev[5] = valid && ((op == 6'h04) || (op == 6'h05)) && branch_taken;
    ev[6] = valid && (op == 6'h00) && (func == 6'h0C);
    ev[7] = valid && (op == 6'h10);
    ev[8] = 1'b1;
    // halted is the registered flag, so the halting cycle itself still counts
    inc   = halted ? '0 : ev;
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == 4'(i)) begin
        rd_next = (SNAP_EN != 0) ? snap_q[i] : cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      overflow <= '0;
      halted   <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (halt) begin
        halted <= 1'b1;
      end
      rd_data <= rd_next;
      if ((SNAP_EN != 0) && snap) begin
        for (int i = 0; i < NCH; i++) begin
          snap_q[i] <= cnt_q[i];
        end
      end
      if (clear) begin
        for (int i = 0; i < NCH; i++) begin
          cnt_q[i] <= '0;
        end
        overflow <= '0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (inc[i]) begin
            if (&cnt_q[i]) begin
              overflow[i] <= 1'b1;
              if (SATURATE == 0) begin
                cnt_q[i] <= '0;
              end
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign cnt_r   = cnt_q[0];
  assign cnt_i   = cnt_q[1];
  assign cnt_j   = cnt_q[2];
  assign cnt_clk = cnt_q[8];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default 11-bit snapshot instance plus
// 4-bit wrap (live read) and 4-bit saturate instances sharing the same stimulus.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       reset, valid, branch_taken, halt, clear, snap;
  logic [5:0] op, func;
  logic [3:0] rd_sel;

  logic [10:0] m_rd, m_r, m_i, m_j, m_clk;
  logic [8:0]  m_ovf;
  logic        m_halted;
  logic [3:0]  w_rd, w_r, w_i, w_j, w_clk;
  logic [8:0]  w_ovf;
  logic        w_halted;
  logic [3:0]  s_rd, s_r, s_i, s_j, s_clk;
  logic [8:0]  s_ovf;
  logic        s_halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.CNT_W(11), .SATURATE(0), .SNAP_EN(1)) u_main (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .func(func),
    .branch_taken(branch_taken), .halt(halt), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(m_rd), .overflow(m_ovf), .halted(m_halted),
    .cnt_r(m_r), .cnt_i(m_i), .cnt_j(m_j), .cnt_clk(m_clk));

  perf_counter_bank #(.CNT_W(4), .SATURATE(0), .SNAP_EN(0)) u_wrap (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .func(func),
    .branch_taken(branch_taken), .halt(halt), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(w_rd), .overflow(w_ovf), .halted(w_halted),
    .cnt_r(w_r), .cnt_i(w_i), .cnt_j(w_j), .cnt_clk(w_clk));

  perf_counter_bank #(.CNT_W(4), .SATURATE(1), .SNAP_EN(1)) u_sat (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .func(func),
    .branch_taken(branch_taken), .halt(halt), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(s_rd), .overflow(s_ovf), .halted(s_halted),
    .cnt_r(s_r), .cnt_i(s_i), .cnt_j(s_j), .cnt_clk(s_clk));

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic bt);
    valid = 1'b1; op = o; func = f; branch_taken = bt;
    step();
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; op = '0; func = '0; branch_taken = 1'b0;
    halt = 1'b0; clear = 1'b0; snap = 1'b0; rd_sel = '0;
    step();
    chk("rst_clk", 32'(m_clk), 0);
    chk("rst_rd", 32'(m_rd), 0);
    chk("rst_ovf", 32'(m_ovf), 0);
    chk("rst_halted", 32'(m_halted), 0);
    reset = 1'b0;

    step(5);
    chk("idle_clk", 32'(m_clk), 5);
    chk("idle_r", 32'(m_r), 0);
    chk("idle_i", 32'(m_i), 0);
    chk("idle_rd", 32'(m_rd), 0);

    instr(6'h00, 6'h20, 1'b0);  // add
    instr(6'h23, 6'h00, 1'b0);  // lw
    instr(6'h2B, 6'h00, 1'b0);  // sw
    instr(6'h02, 6'h00, 1'b0);  // j
    instr(6'h03, 6'h00, 1'b0);  // jal
    instr(6'h10, 6'h00, 1'b0);  // mfc0
    instr(6'h04, 6'h00, 1'b1);  // beq taken
    instr(6'h05, 6'h00, 1'b0);  // bne not taken
    valid = 1'b0; branch_taken = 1'b0;
    chk("mix_clk", 32'(m_clk), 13);
    chk("mix_r", 32'(m_r), 1);
    chk("mix_i", 32'(m_i), 5);
    chk("mix_j", 32'(m_j), 2);

    snap = 1'b1;
    step();                               // edge 14: snapshot of edge-13 values
    snap = 1'b0; rd_sel = 4'd3;
    step();                               // edge 15
    chk("rd_load", 32'(m_rd), 1);
    chk("sat_clk15", 32'(s_clk), 15);
    chk("sat_ovf15", 32'(s_ovf[8]), 0);
    chk("wrap_clk15", 32'(w_clk), 15);
    chk("wrap_ovf15", 32'(w_ovf[8]), 0);
    rd_sel = 4'd4;
    step();                               // edge 16
    chk("rd_store", 32'(m_rd), 1);
    chk("wrap_clk16", 32'(w_clk), 0);
    chk("wrap_ovf16", 32'(w_ovf[8]), 1);
    chk("sat_clk16", 32'(s_clk), 15);
    chk("sat_ovf16", 32'(s_ovf[8]), 1);
    rd_sel = 4'd5;
    step();                               // edge 17
    chk("rd_branch", 32'(m_rd), 1);
    chk("wrap_clk17", 32'(w_clk), 1);
    chk("sat_clk17", 32'(s_clk), 15);
    rd_sel = 4'd6;
    step();
    chk("rd_sys0", 32'(m_rd), 0);
    rd_sel = 4'd7;
    step();
    chk("rd_cop0", 32'(m_rd), 1);
    rd_sel = 4'd8;
    step();                               // edge 20
    chk("rd_snapclk", 32'(m_rd), 13);
    chk("wrap_liverd", 32'(w_rd), 3);     // live 19 mod 16 before edge 20
    rd_sel = 4'd12;
    step();
    chk("rd_sel12", 32'(m_rd), 0);

    instr(6'h00, 6'h0C, 1'b0);            // syscall, edge 22
    valid = 1'b0;
    chk("sys_r", 32'(m_r), 2);
    snap = 1'b1; rd_sel = 4'd6;
    step();                               // edge 23
    chk("snap_same_old", 32'(m_rd), 0);
    snap = 1'b0;
    step();
    chk("snap_new", 32'(m_rd), 1);

    clear = 1'b1;
    step();                               // edge 25
    clear = 1'b0;
    chk("clr_clk", 32'(m_clk), 0);
    chk("clr_r", 32'(m_r), 0);
    chk("clr_wrap_ovf", 32'(w_ovf), 0);
    step(20);
    chk("pre_snapclr_clk", 32'(m_clk), 20);
    snap = 1'b1; clear = 1'b1; rd_sel = 4'd8;
    step();
    chk("snapclr_live", 32'(m_clk), 0);
    chk("snapclr_oldsnap", 32'(m_rd), 22);
    snap = 1'b0; clear = 1'b0;
    step();
    chk("snapclr_rd", 32'(m_rd), 20);
    chk("snapclr_restart", 32'(m_clk), 1);

    rd_sel = 4'd6;
    valid = 1'b1; op = 6'h00; func = 6'h0C; halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_flag", 32'(m_halted), 1);
    chk("halt_r", 32'(m_r), 1);
    chk("halt_clk", 32'(m_clk), 2);
    func = 6'h20;
    step(10);
    valid = 1'b0;
    chk("frz_r", 32'(m_r), 1);
    chk("frz_clk", 32'(m_clk), 2);
    chk("frz_i", 32'(m_i), 0);
    chk("frz_halted", 32'(m_halted), 1);
    chk("frz_wrap_sys", 32'(w_rd), 1);
    chk("frz_wrap_clk", 32'(w_clk), 2);

    reset = 1'b1;
    step();
    chk("rst2_clk", 32'(m_clk), 0);
    chk("rst2_r", 32'(m_r), 0);
    chk("rst2_halted", 32'(m_halted), 0);
    chk("rst2_rd", 32'(m_rd), 0);
    chk("rst2_ovf", 32'(w_ovf), 0);
    reset = 1'b0;
    step();
    chk("rst2_resume", 32'(m_clk), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
